// File: rtl/sram_rd_arbiter.sv
// Round-robin / fixed-priority read-port arbiter for the shared SRAM read path.
// Ports: clk, rst (sync, active-high), select, next, mode, quota -> port_valid, port, grant, round_done.
module sram_rd_arbiter #(
  parameter int PORTS   = 16,
  parameter int PW      = $clog2(PORTS),
  parameter int QUOTA_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PORTS-1:0]   select,
  input  logic               next,
  input  logic               mode,
  input  logic [QUOTA_W-1:0] quota,
  output logic               port_valid,
  output logic [PW-1:0]      port,
  output logic [PORTS-1:0]   grant,
  output logic               round_done
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t             state;
  logic [PW-1:0]      ptr;
  logic [QUOTA_W-1:0] cnt;

  logic [PW-1:0]      nptr;
  logic [PW-1:0]      s;
  logic [PW:0]        hit;
  logic [PW-1:0]      hit_idx;
  logic [PORTS-1:0]   onehot;
  logic [QUOTA_W-1:0] qlim;
  logic               hold;

  // First set bit at or above s, wrapping modulo PORTS.
  // Scanning downward lets the lowest offset overwrite.
  // Result: {found, index}.
  function automatic logic [PW:0] search(
    input logic [PORTS-1:0] req,
    input logic [PW-1:0]    start
  );
    logic [PW:0]   r;
    logic [PW-1:0] ix;
    int            idx;
    r = '0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= PORTS) idx = idx - PORTS;
      ix = PW'(idx);
      if (req[ix]) r = {1'b1, ix};
    end
    return r;
  endfunction

  always_comb begin
    nptr = (port == PW'(PORTS - 1)) ? '0 : port + 1'b1;
    // A consumed read searches past the current port;
    // idle and withdrawal searches start at ptr.
    if (mode)
      s = '0;
    else if (state == GRANT && next)
      s = nptr;
    else
      s = ptr;
    hit     = search(select, s);
    hit_idx = hit[PW-1:0];
    onehot  = '0;
    onehot[hit_idx] = 1'b1;
    qlim = (quota == '0) ? QUOTA_W'(1) : quota;
    hold = (({1'b0, cnt} + 1'b1) < {1'b0, qlim}) && select[port];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      port_valid <= 1'b0;
      port       <= '0;
      grant      <= '0;
      round_done <= 1'b0;
      ptr        <= '0;
      cnt        <= '0;
    end else begin
      round_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hit[PW]) begin
            state      <= GRANT;
            port_valid <= 1'b1;
            port       <= hit_idx;
            grant      <= onehot;
            cnt        <= '0;
          end
        end
        GRANT: begin
          if (next) begin
            if (hold) begin
              cnt <= cnt + 1'b1;
            end else begin
              ptr <= nptr;
              cnt <= '0;
              if (hit[PW]) begin
                port  <= hit_idx;
                grant <= onehot;
                // Wrap (or sole-requester regrant) closes a round.
                if (!mode && hit_idx <= port)
                  round_done <= 1'b1;
              end else begin
                state      <= IDLE;
                port_valid <= 1'b0;
                grant      <= '0;
              end
            end
          end else if (!select[port]) begin
            // Withdrawn without consumption: ptr stays put.
            cnt <= '0;
            if (hit[PW]) begin
              port  <= hit_idx;
              grant <= onehot;
            end else begin
              state      <= IDLE;
              port_valid <= 1'b0;
              grant      <= '0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          port_valid <= 1'b0;
          grant      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_rd_arbiter.sv
// Directed bench for sram_rd_arbiter.
// Drives inputs 1ns after each rising edge and checks registered outputs there.
module tb_sram_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] select;
  logic        next;
  logic        mode;
  logic [3:0]  quota;
  logic        port_valid;
  logic [3:0]  port;
  logic [15:0] grant;
  logic        round_done;

  int checks = 0;
  int errors = 0;

  sram_rd_arbiter #(.PORTS(16), .QUOTA_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .select     (select),
    .next       (next),
    .mode       (mode),
    .quota      (quota),
    .port_valid (port_valid),
    .port       (port),
    .grant      (grant),
    .round_done (round_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks port, valid, grant and round_done together.
  task automatic chk_all(input string tag, input logic v, input logic [3:0] p, input logic rd);
    logic [15:0] g;
    g = v ? (16'h1 << p) : 16'h0;
    chk({tag, ".valid"}, 32'(port_valid), 32'(v));
    if (v) chk({tag, ".port"}, 32'(port), 32'(p));
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".rd"}, 32'(round_done), 32'(rd));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int e [6];
    rst = 1'b1; select = 16'hFFFF; next = 1'b1; mode = 1'b0; quota = 4'd1;

    // Reset state
    tick();
    chk_all("reset", 1'b0, 4'd0, 1'b0);
    chk("reset.port", 32'(port), 32'd0);

    // Full rotation, quota 1
    rst = 1'b0;
    tick();
    chk_all("rr0", 1'b1, 4'd0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk_all($sformatf("rr%0d", k), 1'b1, 4'(k % 16), k == 16);
    end

    // Quota 3 between ports 0 and 2
    rst = 1'b1; select = 16'h0005; quota = 4'd3; next = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk_all("q3.init", 1'b1, 4'd0, 1'b0);
    next = 1'b1;
    e = '{0, 0, 2, 2, 2, 0};
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_all($sformatf("q3.%0d", k), 1'b1, 4'(e[k]), k == 5);
    end

    // Sole requester on port 8, quota 2, next toggling
    rst = 1'b1; select = 16'h0100; quota = 4'd2; next = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk_all("sole.init", 1'b1, 4'd8, 1'b0);
    for (int k = 0; k < 8; k++) begin
      next = (k % 2 == 0);
      tick();
      chk_all($sformatf("sole.%0d", k), 1'b1, 4'd8, (k % 4) == 2);
    end

    // Withdrawal without consumption
    rst = 1'b1; select = 16'h0208; quota = 4'd1; next = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk_all("wd.init", 1'b1, 4'd3, 1'b0);
    select = 16'h0200;
    tick();
    chk_all("wd.sw9", 1'b1, 4'd9, 1'b0);
    // ptr still 0: search from 0 picks 0 over 10
    select = 16'h0401;
    tick();
    chk_all("wd.ptr", 1'b1, 4'd0, 1'b0);
    select = 16'h0000;
    tick();
    chk_all("wd.idle", 1'b0, 4'd0, 1'b0);

    // Fixed priority then back to round-robin
    rst = 1'b1; mode = 1'b1; select = 16'h8001; quota = 4'd1; next = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk_all("fix.init", 1'b1, 4'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_all($sformatf("fix.%0d", k), 1'b1, 4'd0, 1'b0);
    end
    mode = 1'b0;
    tick();
    chk_all("fix.rr15", 1'b1, 4'd15, 1'b0);
    tick();
    chk_all("fix.rr0", 1'b1, 4'd0, 1'b1);

    // Reset mid-burst, then search from 0 again
    rst = 1'b1; select = 16'h0042; quota = 4'd1; next = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk_all("mb.init", 1'b1, 4'd1, 1'b0);
    next = 1'b1;
    tick();
    chk_all("mb.rot", 1'b1, 4'd6, 1'b0);
    quota = 4'd5;
    tick();
    tick();
    chk_all("mb.cnt2", 1'b1, 4'd6, 1'b0);
    rst = 1'b1; next = 1'b0;
    tick();
    chk_all("mb.rst", 1'b0, 4'd0, 1'b0);
    chk("mb.rst.port", 32'(port), 32'd0);
    rst = 1'b0;
    tick();
    chk_all("mb.after", 1'b1, 4'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
